// File: rtl/lcd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_sequencer
//   Drives an SPI byte driver for a small RGB565 LCD. After `start` it walks a
//   fixed init ROM (index bytes, data bytes and timed delays). Once initialised,
//   each `frame_start` programs the full-screen window (CASET/RASET/RAMWR) and
//   streams H_RES*V_RES pixels from the pix_valid/pix_ready source. Each pixel
//   is sent high byte first.
//
//   Optional feature, macro LCD_CLEAR_EN: the init sequence ends by writing
//   the whole screen with CLEAR_COLOR. init_done rises only after the last
//   clear byte, and frame_done does not pulse for the clear.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   start          pulse, begins the init sequence (honoured only in IDLE)
//   frame_start    pulse, begins a full-frame write (honoured only in READY)
//   pix_valid/pix_data/pix_ready   pixel stream, accepted when valid && ready
//   drv_valid      one-cycle byte request to the byte driver
//   drv_rs         0 = index byte, 1 = data byte
//   drv_data       byte to send, held stable until drv_done
//   drv_done       byte complete strobe from the driver
//   busy           high in every state except IDLE and READY
//   init_done      level, initialisation finished
//   frame_done     one-cycle pulse after the last byte of a frame
// -----------------------------------------------------------------------------
module lcd_sequencer #(
    parameter int          DELAY_UNIT  = 1000,
    parameter int          H_RES       = 128,
    parameter int          V_RES       = 160,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        drv_valid,
    output logic        drv_rs,
    output logic [7:0]  drv_data,
    input  logic        drv_done,
    output logic        busy,
    output logic        init_done,
    output logic        frame_done
);

    localparam int TOTAL_PIX = H_RES * V_RES;
    localparam int PIX_W     = $clog2(TOTAL_PIX + 1);
    localparam int DLY_W     = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [3:0] WIN_LAST = 4'd10;

    typedef enum logic [3:0] {
        IDLE, INIT_FETCH, INIT_WAIT, DELAY, READY,
        WIN_ISSUE, WIN_WAIT, PIX_FETCH, PIX_HI, PIX_LO
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         rom_addr_reg, rom_addr_next;
    logic [DLY_W-1:0]   dly_cnt_reg, dly_cnt_next;
    logic [3:0]         win_idx_reg, win_idx_next;
    logic [PIX_W-1:0]   pix_cnt_reg, pix_cnt_next;
    logic [15:0]        pix_reg, pix_next;
    logic               sent_reg, sent_next;     // byte of PIX_HI/PIX_LO already requested
    logic               clear_reg, clear_next;   // current window/pixel run is the init clear
    logic               drv_valid_reg, drv_valid_next;
    logic               drv_rs_reg, drv_rs_next;
    logic [7:0]         drv_data_reg, drv_data_next;
    logic               init_done_reg, init_done_next;
    logic               frame_done_reg, frame_done_next;

    // Init ROM: [9:8] 00 index, 01 data, 10 delay (value * DELAY_UNIT), 11 end.
    logic [9:0] rom_entry;
    always_comb begin
        rom_entry = {2'b11, 8'h00};
        case (rom_addr_reg)
            4'd0: rom_entry = {2'b00, 8'h01};   // software reset
            4'd1: rom_entry = {2'b10, 8'd5};
            4'd2: rom_entry = {2'b00, 8'h11};   // sleep out
            4'd3: rom_entry = {2'b10, 8'd120};
            4'd4: rom_entry = {2'b00, 8'h3A};   // pixel format
            4'd5: rom_entry = {2'b01, 8'h05};   // 16 bpp
            4'd6: rom_entry = {2'b00, 8'h29};   // display on
            default: rom_entry = {2'b11, 8'h00};
        endcase
    end

    // Delay length minus one, so DELAY lasts exactly value * DELAY_UNIT cycles.
    logic [DLY_W-1:0] dly_load;
    assign dly_load = DLY_W'(int'(rom_entry[7:0]) * DELAY_UNIT - 1);

    // Window programming bytes: column range 0..H_RES-1, row range 0..V_RES-1, RAMWR.
    logic       win_rs;
    logic [7:0] win_data;
    always_comb begin
        win_rs   = 1'b1;
        win_data = 8'h00;
        case (win_idx_reg)
            4'd0:    begin win_rs = 1'b0; win_data = 8'h2A; end
            4'd4:    win_data = 8'(H_RES - 1);
            4'd5:    begin win_rs = 1'b0; win_data = 8'h2B; end
            4'd9:    win_data = 8'(V_RES - 1);
            4'd10:   begin win_rs = 1'b0; win_data = 8'h2C; end
            default: win_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            rom_addr_reg   <= '0;
            dly_cnt_reg    <= '0;
            win_idx_reg    <= '0;
            pix_cnt_reg    <= '0;
            pix_reg        <= '0;
            sent_reg       <= 1'b0;
            clear_reg      <= 1'b0;
            drv_valid_reg  <= 1'b0;
            drv_rs_reg     <= 1'b0;
            drv_data_reg   <= '0;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rom_addr_reg   <= rom_addr_next;
            dly_cnt_reg    <= dly_cnt_next;
            win_idx_reg    <= win_idx_next;
            pix_cnt_reg    <= pix_cnt_next;
            pix_reg        <= pix_next;
            sent_reg       <= sent_next;
            clear_reg      <= clear_next;
            drv_valid_reg  <= drv_valid_next;
            drv_rs_reg     <= drv_rs_next;
            drv_data_reg   <= drv_data_next;
            init_done_reg  <= init_done_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rom_addr_next   = rom_addr_reg;
        dly_cnt_next    = dly_cnt_reg;
        win_idx_next    = win_idx_reg;
        pix_cnt_next    = pix_cnt_reg;
        pix_next        = pix_reg;
        sent_next       = sent_reg;
        clear_next      = clear_reg;
        drv_valid_next  = 1'b0;
        drv_rs_next     = drv_rs_reg;
        drv_data_next   = drv_data_reg;
        init_done_next  = init_done_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // frame_start is not looked at here, so start wins when both arrive.
                if (start) begin
                    state_next     = INIT_FETCH;
                    rom_addr_next  = '0;
                    init_done_next = 1'b0;
                end
            end
            INIT_FETCH: begin
                rom_addr_next = rom_addr_reg + 4'd1;
                case (rom_entry[9:8])
                    2'b00, 2'b01: begin
                        drv_valid_next = 1'b1;
                        drv_rs_next    = rom_entry[8];
                        drv_data_next  = rom_entry[7:0];
                        state_next     = INIT_WAIT;
                    end
                    2'b10: begin
                        if (rom_entry[7:0] != 8'd0) begin
                            dly_cnt_next = dly_load;
                            state_next   = DELAY;
                        end
                    end
                    default: begin
                        rom_addr_next = rom_addr_reg;
`ifdef LCD_CLEAR_EN
                        clear_next   = 1'b1;
                        win_idx_next = '0;
                        state_next   = WIN_ISSUE;
`else
                        init_done_next = 1'b1;
                        state_next     = READY;
`endif
                    end
                endcase
            end
            INIT_WAIT: begin
                // Returning through INIT_FETCH keeps the next request one cycle
                // after done, giving the driver its cycle to go idle.
                if (drv_done) state_next = INIT_FETCH;
            end
            DELAY: begin
                if (dly_cnt_reg == '0) state_next = INIT_FETCH;
                else dly_cnt_next = dly_cnt_reg - 1'b1;
            end
            READY: begin
                if (frame_start) begin
                    clear_next   = 1'b0;
                    win_idx_next = '0;
                    state_next   = WIN_ISSUE;
                end
            end
            WIN_ISSUE: begin
                drv_valid_next = 1'b1;
                drv_rs_next    = win_rs;
                drv_data_next  = win_data;
                state_next     = WIN_WAIT;
            end
            WIN_WAIT: begin
                if (drv_done) begin
                    if (win_idx_reg == WIN_LAST) begin
                        win_idx_next = '0;
                        pix_cnt_next = '0;
                        if (clear_reg) begin
                            pix_next   = CLEAR_COLOR;
                            state_next = PIX_HI;
                        end else begin
                            state_next = PIX_FETCH;
                        end
                    end else begin
                        win_idx_next = win_idx_reg + 4'd1;
                        state_next   = WIN_ISSUE;
                    end
                end
            end
            PIX_FETCH: begin
                if (pix_valid) begin
                    pix_next   = pix_data;
                    state_next = PIX_HI;
                end
            end
            PIX_HI: begin
                if (!sent_reg) begin
                    drv_valid_next = 1'b1;
                    drv_rs_next    = 1'b1;
                    drv_data_next  = pix_reg[15:8];
                    sent_next      = 1'b1;
                end else if (drv_done) begin
                    sent_next  = 1'b0;
                    state_next = PIX_LO;
                end
            end
            PIX_LO: begin
                if (!sent_reg) begin
                    drv_valid_next = 1'b1;
                    drv_rs_next    = 1'b1;
                    drv_data_next  = pix_reg[7:0];
                    sent_next      = 1'b1;
                end else if (drv_done) begin
                    sent_next    = 1'b0;
                    pix_cnt_next = pix_cnt_reg + 1'b1;
                    if (pix_cnt_reg == PIX_W'(TOTAL_PIX - 1)) begin
                        pix_cnt_next = '0;
                        state_next   = READY;
                        if (clear_reg) begin
                            clear_next     = 1'b0;
                            init_done_next = 1'b1;
                        end else begin
                            frame_done_next = 1'b1;
                        end
                    end else if (clear_reg) begin
                        state_next = PIX_HI;      // pix_reg still holds CLEAR_COLOR
                    end else begin
                        state_next = PIX_FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pix_ready  = (state_reg == PIX_FETCH);
    assign busy       = (state_reg != IDLE) && (state_reg != READY);
    assign drv_valid  = drv_valid_reg;
    assign drv_rs     = drv_rs_reg;
    assign drv_data   = drv_data_reg;
    assign init_done  = init_done_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_sequencer
//   Bench for lcd_sequencer with DELAY_UNIT=4, H_RES=2, V_RES=2. A byte-driver
//   model answers every drv_valid with drv_done 18 cycles later and logs the
//   (rs,data) stream; scenarios compare that stream against expected bytes
//   built from fixed tables and from a pixel-to-byte model.
//   Define LCD_CLEAR_EN for both DUT and bench to cover the screen clear.
// -----------------------------------------------------------------------------
module tb_lcd_sequencer;

    localparam int          DU = 4;
    localparam int          H  = 2;
    localparam int          V  = 2;
    localparam logic [15:0] CC = 16'hF800;

    logic        clk = 1'b0;
    logic        rstn, start, frame_start, pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready, drv_valid, drv_rs, drv_done, busy, init_done, frame_done;
    logic [7:0]  drv_data;
    logic        drv_done_m = 1'b0;
    logic        stray_done = 1'b0;

    assign drv_done = drv_done_m | stray_done;

    lcd_sequencer #(.DELAY_UNIT(DU), .H_RES(H), .V_RES(V), .CLEAR_COLOR(CC)) dut (
        .clk(clk), .rstn(rstn), .start(start), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .drv_valid(drv_valid), .drv_rs(drv_rs), .drv_data(drv_data),
        .drv_done(drv_done), .busy(busy), .init_done(init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- byte driver model / monitor ----------------
    int         ncyc = 0;
    logic [8:0] cap_q[$];
    int         cap_vcyc[$];
    int         cap_dcyc[$];
    int         frame_done_cnt = 0;
    bit         drv_active = 0;
    int         drv_cnt = 0;
    logic [8:0] drv_held = '0;
    int         stable_err = 0;
    int         overlap_err = 0;

    always @(negedge clk) begin
        ncyc++;
        if (!rstn) begin
            if (drv_active) cap_dcyc.push_back(-1);   // byte aborted by reset
            drv_active = 0;
            drv_done_m = 1'b0;
        end else begin
            drv_done_m = 1'b0;
            if (drv_active) begin
                if ({drv_rs, drv_data} !== drv_held) stable_err++;
                drv_cnt--;
                if (drv_cnt == 0) begin
                    drv_done_m = 1'b1;
                    drv_active = 0;
                    cap_dcyc.push_back(ncyc);
                end
            end
            if (drv_valid) begin
                if (drv_active) overlap_err++;
                drv_active = 1;
                drv_cnt    = 17;
                drv_held   = {drv_rs, drv_data};
                cap_q.push_back({drv_rs, drv_data});
                cap_vcyc.push_back(ncyc);
            end
            if (frame_done) frame_done_cnt++;
        end
    end

    // ---------------- tables and model ----------------
    typedef struct { logic rs; logic [7:0] data; } init_vec_t;
    typedef struct { logic [15:0] pix; logic [7:0] hi; logic [7:0] lo; } frame_vec_t;
    init_vec_t  init_tbl[5];
    frame_vec_t frame_tbl[4];
    logic [8:0]  exp_q[$];
    logic [15:0] pix_q[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_window();
        exp_q.push_back({1'b0, 8'h2A});
        repeat (3) exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(H - 1)});
        exp_q.push_back({1'b0, 8'h2B});
        repeat (3) exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(V - 1)});
        exp_q.push_back({1'b0, 8'h2C});
    endfunction

    // Pixel model: each pixel becomes two data bytes, high byte first.
    function automatic void push_pixel(input logic [15:0] p);
        exp_q.push_back({1'b1, 8'(p >> 8)});
        exp_q.push_back({1'b1, 8'(p & 16'h00FF)});
    endfunction

    task automatic cmp_bytes(input string tag, input int base);
        chk({tag, "_len"}, cap_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < cap_q.size())
                chk($sformatf("%s_b%0d", tag, k), cap_q[base + k], exp_q[k]);
            else
                chk($sformatf("%s_b%0d_missing", tag, k), 32'hFFFF_FFFF, exp_q[k]);
        end
    endtask

    task automatic run_init(input bit both);
        int base, g, nid, gp, fd0;
        logic [15:0] cc;
        base = cap_q.size();
        fd0  = frame_done_cnt;
        start = 1'b1;
        frame_start = both;
        tick();
        start = 1'b0;
        frame_start = 1'b0;
        g = 0;
        while (!init_done && g < 6000) begin tick(); g++; end
        nid = ncyc;
        chk("init_done_set", init_done, 1);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({init_tbl[i].rs, init_tbl[i].data});
`ifdef LCD_CLEAR_EN
        cc = CC;
        push_window();
        for (int i = 0; i < H * V; i++) push_pixel(cc);
`else
        cc = 16'h0000;
`endif
        cmp_bytes("init", base);
        if (cap_dcyc.size() >= base + 5 && cap_vcyc.size() >= base + 5) begin
            gp = cap_vcyc[base + 3] - cap_dcyc[base + 2];
            chk("gap_plain_ge1", (gp >= 1), 1);
            // a delay entry costs its own fetch cycle plus value*DELAY_UNIT cycles
            chk("gap_delay5",   cap_vcyc[base + 1] - cap_dcyc[base + 0], gp + 1 + 5 * DU);
            chk("gap_delay120", cap_vcyc[base + 2] - cap_dcyc[base + 1], gp + 1 + 120 * DU);
`ifdef LCD_CLEAR_EN
            chk("clear_no_frame_done", frame_done_cnt - fd0, 0);
            chk("init_after_clear", (nid > cap_dcyc[cap_dcyc.size() - 1]), 1);
`else
            // done -> fetch end entry -> init_done visible next cycle
            chk("init_done_latency", nid - cap_dcyc[base + 4], 2);
`endif
        end else begin
            chk("init_bytes_done", cap_dcyc.size() - base, 5);
        end
        // frame_start given together with start must not have started a frame
        repeat (40) tick();
        chk("init_quiet_after", cap_q.size() - base, exp_q.size());
        chk("init_idle_busy", busy, 0);
        if (cc == 16'hFFFF) chk("cc_unused", cc, 0);
    endtask

    // Sends pix_q as one frame; exp_q must already hold the expected bytes.
    task automatic run_frame(input string tag, input bit rand_valid, input int stall_at,
                             input bit poke_fs);
        int base, fd0, i, guard, v0;
        bit hs, stalled, rdy_ok;
        base = cap_q.size();
        fd0  = frame_done_cnt;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        i = 0; guard = 0; stalled = 0;
        while (i < pix_q.size() && guard < 5000) begin
            if (stall_at == i && !stalled && pix_ready) begin
                v0 = cap_q.size();
                rdy_ok = 1;
                pix_valid = 1'b0;
                repeat (50) begin tick(); if (!pix_ready) rdy_ok = 0; end
                chk("stall_no_drv_valid", cap_q.size() - v0, 0);
                chk("stall_ready_held", rdy_ok, 1);
                stalled = 1;
            end
            pix_valid   = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_data    = pix_valid ? pix_q[i] : 16'($urandom);
            frame_start = (poke_fs && i == 1) ? 1'b1 : 1'b0;   // must be ignored mid-frame
            hs = pix_valid && pix_ready;
            tick();
            if (hs) i++;
            guard++;
        end
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        chk({tag, "_all_pixels_taken"}, i, pix_q.size());
        guard = 0;
        while (busy && guard < 2000) begin tick(); guard++; end
        repeat (3) tick();
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_ready_low"}, pix_ready, 0);
        chk({tag, "_frame_done_once"}, frame_done_cnt - fd0, 1);
        cmp_bytes(tag, base);
    endtask

    task automatic load_table_frame();
        pix_q.delete();
        exp_q.delete();
        push_window();
        for (int i = 0; i < 4; i++) begin
            pix_q.push_back(frame_tbl[i].pix);
            exp_q.push_back({1'b1, frame_tbl[i].hi});
            exp_q.push_back({1'b1, frame_tbl[i].lo});
        end
    endtask

    initial begin
        int base, fd0, g;
        init_tbl[0] = '{1'b0, 8'h01};
        init_tbl[1] = '{1'b0, 8'h11};
        init_tbl[2] = '{1'b0, 8'h3A};
        init_tbl[3] = '{1'b1, 8'h05};
        init_tbl[4] = '{1'b0, 8'h29};
        frame_tbl[0] = '{16'h1234, 8'h12, 8'h34};
        frame_tbl[1] = '{16'hABCD, 8'hAB, 8'hCD};
        frame_tbl[2] = '{16'h0F0F, 8'h0F, 8'h0F};
        frame_tbl[3] = '{16'hF0F0, 8'hF0, 8'hF0};

        rstn = 1'b0; start = 1'b0; frame_start = 1'b0;
        pix_valid = 1'b0; pix_data = 16'h0;
        repeat (3) tick();
        chk("reset_outputs", {drv_valid, drv_rs, drv_data, pix_ready, busy, init_done, frame_done}, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // frame_start before any init is ignored
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (20) tick();
        chk("idle_ignores_frame_start", {busy, 9'(cap_q.size())}, 0);

        // init, with start and frame_start together
        run_init(1'b1);

        // frame from the table
        load_table_frame();
        run_frame("frame_tbl", 1'b0, -1, 1'b0);

        // start and a stray drv_done in READY are both ignored
        base = cap_q.size();
        start = 1'b1; stray_done = 1'b1; tick(); start = 1'b0; stray_done = 1'b0;
        repeat (30) tick();
        chk("ready_ignores_start", cap_q.size() - base, 0);
        chk("ready_not_busy", busy, 0);
        chk("ready_init_done_held", init_done, 1);

        // 50-cycle stall before the third pixel
        load_table_frame();
        run_frame("frame_stall", 1'b0, 2, 1'b0);

        // random pixels and random pix_valid, frame_start poked mid-frame
        for (int f = 0; f < 3; f++) begin
            pix_q.delete();
            exp_q.delete();
            push_window();
            for (int i = 0; i < H * V; i++) begin
                pix_q.push_back(16'($urandom));
                push_pixel(pix_q[i]);
            end
            run_frame($sformatf("frame_rand%0d", f), 1'b1, -1, 1'b1);
        end

        // reset during the second pixel byte
        base = cap_q.size();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pix_valid = 1'b1; pix_data = 16'h1234;
        g = 0;
        while (cap_q.size() < base + 13 && g < 2000) begin tick(); g++; end
        chk("reached_second_pixel_byte", cap_q.size() - base, 13);
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            {drv_valid, drv_rs, drv_data, pix_ready, busy, init_done, frame_done}, 0);
        tick();
        chk("midframe_reset_held",
            {drv_valid, drv_rs, drv_data, pix_ready, busy, init_done, frame_done}, 0);
        pix_valid = 1'b0;
        rstn = 1'b1;
        repeat (2) tick();
        base = cap_q.size();
        fd0  = frame_done_cnt;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (60) tick();
        chk("post_reset_frame_start_ignored", cap_q.size() - base, 0);
        chk("post_reset_idle", {busy, init_done}, 0);
        chk("post_reset_no_frame_done", frame_done_cnt - fd0, 0);

        // fresh init and frame after reset
        run_init(1'b0);
        load_table_frame();
        run_frame("frame_after_reset", 1'b0, -1, 1'b0);

        chk("drv_hold_stable", stable_err, 0);
        chk("drv_one_request_at_a_time", overlap_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL global_timeout: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
